// File: rtl/audio_dac_pkg.sv
// audio_dac_pkg: shared modulation-mode encodings and midscale helper for the audio DAC driver
package audio_dac_pkg;
  localparam logic MODE_PWM = 1'b0;
  localparam logic MODE_SDM = 1'b1;
  function automatic logic [31:0] midscale(input int n);
    return 32'd1 << (n - 1);
  endfunction
endpackage

// File: rtl/audio_dac_channel.sv
// audio_dac_channel: one PCM lane -> capture, offset conversion, PWM/SDM +1 decision, saturating registered DAC code
// Ports: clk, reset_n (async active-low); i_pcm signed sample, i_valid capture strobe;
//        i_cnt shared PWM counter, i_mode registered mode, i_clear mode-change clear,
//        i_force drive midscale; o_dac registered unsigned DAC code.
module audio_dac_channel
  import audio_dac_pkg::*;
#(
  parameter int PCM_BITS = 16,
  parameter int DAC_BITS = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [PCM_BITS-1:0]          i_pcm,
  input  logic                         i_valid,
  input  logic [PCM_BITS-DAC_BITS-1:0] i_cnt,
  input  logic                         i_mode,
  input  logic                         i_clear,
  input  logic                         i_force,
  output logic [DAC_BITS-1:0]          o_dac
);
  localparam int L = PCM_BITS - DAC_BITS;
  localparam logic [DAC_BITS-1:0] MID = DAC_BITS'(midscale(DAC_BITS));
  logic [PCM_BITS-1:0] r_pcm;
  logic [L-1:0]        r_acc;
  logic [DAC_BITS-1:0] r_dac;
  logic [PCM_BITS-1:0] w_u;
  logic [DAC_BITS-1:0] w_hi;
  logic [L-1:0]        w_lo;
  logic [L:0]          w_sum;
  logic                w_bump;
  logic [DAC_BITS-1:0] w_code;
  // Flipping the sign bit maps signed PCM onto an unsigned code centred at midscale.
  assign w_u    = {~r_pcm[PCM_BITS-1], r_pcm[PCM_BITS-2:0]};
  assign w_hi   = w_u[PCM_BITS-1:L];
  assign w_lo   = w_u[L-1:0];
  assign w_sum  = {1'b0, r_acc} + {1'b0, w_lo};
  assign w_bump = (i_mode == MODE_SDM) ? w_sum[L] : (w_lo > i_cnt);
  // A full-scale code holds instead of wrapping to zero.
  assign w_code = &w_hi ? w_hi : w_hi + DAC_BITS'(w_bump);
  assign o_dac  = r_dac;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pcm <= '0;
      r_acc <= '0;
      r_dac <= MID;
    end else begin
      if (i_valid) r_pcm <= i_pcm;
      r_acc <= i_clear ? '0 : w_sum[L-1:0];
      r_dac <= i_force ? MID : w_code;
    end
  end
endmodule

// File: rtl/audio_dac_multi.sv
// audio_dac_multi: N-channel PCM to low-bit DAC driver with run-time PWM/sigma-delta, mute and underrun watchdog
// Ports: clk, reset_n (async active-low); pcm_in packed signed samples (ch0 in LSBs);
//        pcm_valid capture strobe; mode 0=PWM 1=SDM; mute forces midscale;
//        dac_out packed unsigned codes (ch0 in LSBs); underrun high while the watchdog has expired.
module audio_dac_multi
  import audio_dac_pkg::*;
#(
  parameter int CHANNELS       = 2,
  parameter int PCM_BITS       = 16,
  parameter int DAC_BITS       = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [CHANNELS*PCM_BITS-1:0] pcm_in,
  input  logic                         pcm_valid,
  input  logic                         mode,
  input  logic                         mute,
  output logic [CHANNELS*DAC_BITS-1:0] dac_out,
  output logic                         underrun
);
  localparam int L  = PCM_BITS - DAC_BITS;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] TMO = WW'(TIMEOUT_CYCLES);
  logic [L-1:0]  r_cnt;
  logic          r_mode;
  logic [WW-1:0] r_wd;
  logic          r_underrun;
  logic          w_chg;
  logic [WW-1:0] w_wd_nxt;
  logic          w_ur_nxt;
  logic          w_force;
  assign w_chg    = mode != r_mode;
  assign w_wd_nxt = pcm_valid ? '0 : (r_wd == TMO) ? r_wd : r_wd + WW'(1);
  // Underrun is sticky until the next pcm_valid, which also covers the post-reset state.
  assign w_ur_nxt = !pcm_valid && (r_underrun || w_wd_nxt == TMO);
  assign w_force  = mute || w_ur_nxt;
  assign underrun = r_underrun;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_mode     <= MODE_PWM;
      r_wd       <= '0;
      r_underrun <= 1'b1;
    end else begin
      r_cnt      <= w_chg ? '0 : r_cnt + L'(1);
      r_mode     <= mode;
      r_wd       <= w_wd_nxt;
      r_underrun <= w_ur_nxt;
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    audio_dac_channel #(
      .PCM_BITS(PCM_BITS),
      .DAC_BITS(DAC_BITS)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .i_pcm  (pcm_in[c*PCM_BITS +: PCM_BITS]),
      .i_valid(pcm_valid),
      .i_cnt  (r_cnt),
      .i_mode (r_mode),
      .i_clear(w_chg),
      .i_force(w_force),
      .o_dac  (dac_out[c*DAC_BITS +: DAC_BITS])
    );
  end
endmodule
